// File: rtl/bcd_counter_display.sv
// bcd_counter_display
//   Multi-digit BCD up/down counter stepped by three push-buttons and shown on a
//   time-multiplexed seven-segment display.
//
//   Parameters
//     DIGITS          number of BCD digits (1..8)
//     DEBOUNCE_CYCLES stable cycles needed to accept a button level change (>=2)
//     REFRESH_CYCLES  cycles each digit stays enabled per scan step (>=2)
//     BLANK_LZ        1 = blank leading zeros above digit 0
//
//   Ports
//     clk        system clock, rising edge
//     reset_n    asynchronous active-low reset
//     btn_inc    raw increment button (async, active-high)
//     btn_dec    raw decrement button (async, active-high)
//     btn_clr    raw clear button (async, active-high, level acts while held)
//     seg        segments {top, upper-left, upper-right, middle, lower-right, lower-left, bottom}
//     digit_en   one-hot digit enable
//     count_bcd  current count, digit i in [4i+3:4i]
//     wrap       one-cycle pulse when the count wraps in either direction

// Per-button conditioner: 2-flop synchroniser followed by a counting debouncer.
module bcd_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync    <= 2'b00;
            cnt     <= '0;
            level_q <= 1'b0;
        end else begin
            sync <= {sync[0], btn_raw};
            if (sync[1] == level_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Input has disagreed with the accepted level long enough.
                level_q <= sync[1];
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = level_q;
endmodule

module bcd_counter_display #(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REFRESH_CYCLES  = 100000,
    parameter int BLANK_LZ        = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  btn_inc,
    input  logic                  btn_dec,
    input  logic                  btn_clr,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_en,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

    // ---------------- button conditioning: lane 0 inc, 1 dec, 2 clr
    logic [2:0] btn_raw;
    logic [2:0] lvl;
    logic [1:0] lvl_q;
    logic       inc_p, dec_p, clr_l;

    assign btn_raw = {btn_clr, btn_dec, btn_inc};

    genvar b;
    generate
        for (b = 0; b < 3; b++) begin : g_btn
            bcd_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
                .clk     (clk),
                .reset_n (reset_n),
                .btn_raw (btn_raw[b]),
                .level   (lvl[b])
            );
        end
    endgenerate

    // Only press edges of inc/dec step the count; clear acts on its level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lvl_q <= 2'b00;
        else          lvl_q <= lvl[1:0];
    end

    assign inc_p = lvl[0] & ~lvl_q[0];
    assign dec_p = lvl[1] & ~lvl_q[1];
    assign clr_l = lvl[2];

    // ---------------- BCD counter
    logic [DIGITS-1:0][3:0] cnt, inc_val, dec_val, cnt_nxt;
    logic                   inc_c, dec_b, wrap_nxt;

    // Ripple carry/borrow; a carry/borrow surviving the top digit means wrap.
    always_comb begin
        inc_val = cnt;
        dec_val = cnt;
        inc_c   = 1'b1;
        dec_b   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_c) begin
                if (cnt[i] == 4'd9) begin
                    inc_val[i] = 4'd0;
                end else begin
                    inc_val[i] = cnt[i] + 4'd1;
                    inc_c      = 1'b0;
                end
            end
            if (dec_b) begin
                if (cnt[i] == 4'd0) begin
                    dec_val[i] = 4'd9;
                end else begin
                    dec_val[i] = cnt[i] - 4'd1;
                    dec_b      = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        if (clr_l) begin
            cnt_nxt = '0;
        end else if (inc_p && dec_p) begin
            cnt_nxt = cnt;
        end else if (inc_p) begin
            cnt_nxt  = inc_val;
            wrap_nxt = inc_c;
        end else if (dec_p) begin
            cnt_nxt  = dec_val;
            wrap_nxt = dec_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            wrap <= wrap_nxt;
        end
    end

    assign count_bcd = cnt;

    // ---------------- display scan
    logic [RW-1:0] refresh;
    logic [IW-1:0] scan_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh  <= '0;
            scan_idx <= '0;
        end else if (refresh == REF_LAST) begin
            refresh  <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end else begin
            refresh <= refresh + 1'b1;
        end
    end

    // hi_zero[i]: digit i and all digits above it are zero.
    logic [DIGITS-1:0] hi_zero;
    always_comb begin
        hi_zero = '0;
        hi_zero[DIGITS-1] = (cnt[DIGITS-1] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            hi_zero[i] = hi_zero[i+1] && (cnt[i] == 4'd0);
        end
    end

    logic [3:0] cur_digit;
    logic       blank;

    assign digit_en  = DIGITS'(1) << scan_idx;
    assign cur_digit = cnt[scan_idx];
    assign blank     = (BLANK_LZ != 0) && (scan_idx != '0) && hi_zero[scan_idx];

    always_comb begin
        seg = 7'h08;
        if (!blank) begin
            case (cur_digit)
                4'd0:    seg = 7'h77;
                4'd1:    seg = 7'h14;
                4'd2:    seg = 7'h5B;
                4'd3:    seg = 7'h5D;
                4'd4:    seg = 7'h3C;
                4'd5:    seg = 7'h6D;
                4'd6:    seg = 7'h2F;
                4'd7:    seg = 7'h54;
                4'd8:    seg = 7'h7F;
                4'd9:    seg = 7'h7C;
                default: seg = 7'h08;
            endcase
        end else begin
            seg = 7'h00;
        end
    end
endmodule

// File: tb/tb_bcd_counter_display.sv
module tb_bcd_counter_display;
    localparam int D = 4;
    localparam int R = 8;
    localparam int N = 2;

    logic       clk = 1'b0;
    logic       reset_n, btn_inc, btn_dec, btn_clr;
    logic [6:0] seg;
    logic [1:0] digit_en;
    logic [7:0] count_bcd;
    logic       wrap;

    int n_chk = 0;
    int n_fail = 0;
    int wrap_cnt = 0;
    int cyc = 0;
    int m_val = 0;

    logic [6:0] seg_tbl [10] = '{7'h77, 7'h14, 7'h5B, 7'h5D, 7'h3C,
                                 7'h6D, 7'h2F, 7'h54, 7'h7F, 7'h7C};

    bcd_counter_display #(
        .DIGITS(N), .DEBOUNCE_CYCLES(D), .REFRESH_CYCLES(R), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .btn_clr(btn_clr), .seg(seg), .digit_en(digit_en),
        .count_bcd(count_bcd), .wrap(wrap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wrap === 1'b1) wrap_cnt++;

    // Cycles since reset release; drives the expected scan position.
    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    function automatic logic [7:0] exp_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int idx);
        int d;
        d = (idx == 1) ? v / 10 : v % 10;
        if (idx == 1 && v < 10) return 7'h00;
        return seg_tbl[d];
    endfunction

    // which: 0 inc, 1 dec, 2 clr, 3 inc+dec, 4 inc+clr
    task automatic press(input int which, input int hold, input int gap);
        if (which == 0 || which == 3 || which == 4) btn_inc = 1'b1;
        if (which == 1 || which == 3) btn_dec = 1'b1;
        if (which == 2 || which == 4) btn_clr = 1'b1;
        repeat (hold) @(negedge clk);
        btn_inc = 1'b0; btn_dec = 1'b0; btn_clr = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_val = 0;
        n_chk++; if (count_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h expected 00", count_bcd); end
        n_chk++; if (digit_en !== 2'b01) begin n_fail++; $display("FAIL reset_digit_en: got %b expected 01", digit_en); end
        n_chk++; if (seg !== 7'h77) begin n_fail++; $display("FAIL reset_seg: got %h expected 77", seg); end
        n_chk++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
        repeat (7) @(negedge clk);
        n_chk++; if (digit_en !== 2'b01) begin n_fail++; $display("FAIL scan_hold7: got %b expected 01", digit_en); end
        @(negedge clk);
        n_chk++; if (digit_en !== 2'b10) begin n_fail++; $display("FAIL scan_step8: got %b expected 10", digit_en); end
        n_chk++; if (seg !== 7'h00) begin n_fail++; $display("FAIL scan_blank: got %h expected 00", seg); end
    endtask

    task automatic test_single_inc;
        int w0;
        w0 = wrap_cnt;
        btn_inc = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            // k posedges seen (edges 0..k-1); step lands on edge D+2
            n_chk++;
            if (count_bcd !== exp_bcd((k >= D + 3) ? 1 : 0)) begin
                n_fail++; $display("FAIL single_inc_k%0d: got %h expected %h", k, count_bcd, exp_bcd((k >= D + 3) ? 1 : 0));
            end
        end
        btn_inc = 1'b0;
        repeat (15) @(negedge clk);
        m_val = 1;
        n_chk++; if (count_bcd !== 8'h01) begin n_fail++; $display("FAIL single_inc_release: got %h expected 01", count_bcd); end
        n_chk++; if (wrap_cnt != w0) begin n_fail++; $display("FAIL single_inc_wrap: got %0d expected %0d", wrap_cnt, w0); end
    endtask

    task automatic test_carry;
        int guard;
        repeat (8) press(0, 10, 12);
        m_val = 9;
        n_chk++; if (count_bcd !== exp_bcd(m_val)) begin n_fail++; $display("FAIL carry_09: got %h expected %h", count_bcd, exp_bcd(m_val)); end
        press(0, 10, 12);
        m_val = 10;
        n_chk++; if (count_bcd !== 8'h10) begin n_fail++; $display("FAIL carry_10: got %h expected 10", count_bcd); end
        guard = 0;
        while (digit_en !== 2'b10 && guard < 3 * R) begin @(negedge clk); guard++; end
        n_chk++; if (digit_en !== 2'b10) begin n_fail++; $display("FAIL carry_scan_timeout: got %b expected 10", digit_en); end
        n_chk++; if (seg !== 7'h14) begin n_fail++; $display("FAIL carry_digit1_seg: got %h expected 14", seg); end
    endtask

    task automatic test_dec;
        int w0;
        w0 = wrap_cnt;
        press(1, 10, 12);
        m_val = 9;
        n_chk++; if (count_bcd !== 8'h09) begin n_fail++; $display("FAIL dec_borrow: got %h expected 09", count_bcd); end
        n_chk++; if (wrap_cnt != w0) begin n_fail++; $display("FAIL dec_borrow_wrap: got %0d expected %0d", wrap_cnt, w0); end
        reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
        m_val = 0;
        press(1, 10, 12);
        m_val = 99;
        n_chk++; if (count_bcd !== 8'h99) begin n_fail++; $display("FAIL dec_wrap_99: got %h expected 99", count_bcd); end
        n_chk++; if (wrap_cnt != w0 + 1) begin n_fail++; $display("FAIL dec_wrap_pulse: got %0d expected %0d", wrap_cnt, w0 + 1); end
    endtask

    task automatic test_wrap_up;
        int w0;
        w0 = wrap_cnt;
        press(0, 10, 12);
        m_val = 0;
        n_chk++; if (count_bcd !== 8'h00) begin n_fail++; $display("FAIL inc_wrap_00: got %h expected 00", count_bcd); end
        n_chk++; if (wrap_cnt != w0 + 1) begin n_fail++; $display("FAIL inc_wrap_pulse: got %0d expected %0d", wrap_cnt, w0 + 1); end
    endtask

    task automatic test_bounce;
        btn_inc = 1'b1; repeat (3) @(negedge clk);
        btn_inc = 1'b0; repeat (1) @(negedge clk);
        btn_inc = 1'b1; repeat (2) @(negedge clk);
        btn_inc = 1'b0; repeat (12) @(negedge clk);
        n_chk++; if (count_bcd !== exp_bcd(m_val)) begin n_fail++; $display("FAIL bounce_reject: got %h expected %h", count_bcd, exp_bcd(m_val)); end
        press(0, 10, 12);
        m_val = (m_val + 1) % 100;
        n_chk++; if (count_bcd !== exp_bcd(m_val)) begin n_fail++; $display("FAIL bounce_then_hold: got %h expected %h", count_bcd, exp_bcd(m_val)); end
    endtask

    task automatic test_simultaneous;
        int w0;
        w0 = wrap_cnt;
        press(3, 10, 12);
        n_chk++; if (count_bcd !== exp_bcd(m_val)) begin n_fail++; $display("FAIL simul_count: got %h expected %h", count_bcd, exp_bcd(m_val)); end
        n_chk++; if (wrap_cnt != w0) begin n_fail++; $display("FAIL simul_wrap: got %0d expected %0d", wrap_cnt, w0); end
    endtask

    task automatic test_clear;
        int w0;
        btn_clr = 1'b1;
        repeat (8) @(negedge clk);
        m_val = 0;
        n_chk++; if (count_bcd !== 8'h00) begin n_fail++; $display("FAIL clear_level: got %h expected 00", count_bcd); end
        // press() releases every button, so drive inc by hand while clr stays high
        repeat (2) begin
            btn_inc = 1'b1; repeat (10) @(negedge clk);
            btn_inc = 1'b0; repeat (12) @(negedge clk);
        end
        n_chk++; if (count_bcd !== 8'h00) begin n_fail++; $display("FAIL clear_blocks_inc: got %h expected 00", count_bcd); end
        btn_clr = 1'b0;
        repeat (12) @(negedge clk);
        press(0, 10, 12);
        m_val = 1;
        n_chk++; if (count_bcd !== 8'h01) begin n_fail++; $display("FAIL clear_release_inc: got %h expected 01", count_bcd); end
        w0 = wrap_cnt;
        press(4, 10, 12);
        m_val = 0;
        n_chk++; if (count_bcd !== 8'h00) begin n_fail++; $display("FAIL clear_wins: got %h expected 00", count_bcd); end
        n_chk++; if (wrap_cnt != w0) begin n_fail++; $display("FAIL clear_wins_wrap: got %0d expected %0d", wrap_cnt, w0); end
    endtask

    task automatic test_reset_mid;
        btn_inc = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        m_val = 0;
        n_chk++; if (count_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_mid_count: got %h expected 00", count_bcd); end
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_chk++;
            if (count_bcd !== exp_bcd((k >= D + 3) ? 1 : 0)) begin
                n_fail++; $display("FAIL reset_mid_k%0d: got %h expected %h", k, count_bcd, exp_bcd((k >= D + 3) ? 1 : 0));
            end
        end
        btn_inc = 1'b0;
        repeat (12) @(negedge clk);
        m_val = 1;
    endtask

    task automatic test_random;
        int op, hold, w0, exp_w, idx;
        for (int it = 0; it < 30; it++) begin
            op = int'($urandom_range(0, 5));
            w0 = wrap_cnt;
            exp_w = 0;
            if (op <= 1) begin
                press(0, int'($urandom_range(D + 2, 12)), 12);
                if (m_val == 99) exp_w = 1;
                m_val = (m_val + 1) % 100;
            end else if (op <= 3) begin
                press(1, int'($urandom_range(D + 2, 12)), 12);
                if (m_val == 0) exp_w = 1;
                m_val = (m_val + 99) % 100;
            end else if (op == 4) begin
                press(2, int'($urandom_range(D + 2, 12)), 12);
                m_val = 0;
            end else begin
                hold = int'($urandom_range(1, D - 1));
                press(int'($urandom_range(0, 1)), hold, 12);
            end
            n_chk++; if (count_bcd !== exp_bcd(m_val)) begin n_fail++; $display("FAIL rand_count_it%0d: got %h expected %h", it, count_bcd, exp_bcd(m_val)); end
            n_chk++; if (wrap_cnt - w0 != exp_w) begin n_fail++; $display("FAIL rand_wrap_it%0d: got %0d expected %0d", it, wrap_cnt - w0, exp_w); end
            idx = (cyc / R) % N;
            n_chk++; if (digit_en !== 2'(1 << idx)) begin n_fail++; $display("FAIL rand_digit_en_it%0d: got %b expected %b", it, digit_en, 2'(1 << idx)); end
            n_chk++; if (seg !== exp_seg(m_val, idx)) begin n_fail++; $display("FAIL rand_seg_it%0d: got %h expected %h", it, seg, exp_seg(m_val, idx)); end
        end
    endtask

    initial begin
        reset_n = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_clr = 1'b0;
        test_reset();
        test_single_inc();
        test_carry();
        test_dec();
        test_wrap_up();
        test_bounce();
        test_simultaneous();
        test_clear();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
